gmsk_burst_sequencer: RTL and testbench

- Sequences one GSM normal burst into the GMSK I/Q modulator.
- Generates the modulator's sample_strobe from a clock divider and supplies current_symbol at each symbol boundary.
- Frames each burst: head tail bits, streamed payload, trail tail bits, flush, then guard.
- Sits between the burst bit source (stream handshake) and the modulator; drives tx_enable to the RF front-end gating.

---
 rtl/gmsk_pkg.sv | 49 ++++
 rtl/gmsk_burst_sequencer_if.sv | 9 +
 rtl/gmsk_strobe_divider.sv | 27 ++
 rtl/gmsk_burst_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_gmsk_burst_sequencer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gmsk_pkg.sv
// Shared types and defaults for the GMSK burst sequencer and its divider.
package gmsk_pkg;

    localparam int unsigned SAMPLES_PER_SYMBOL    = 31;
    localparam int unsigned DEFAULT_SAMPLE_DIVIDE = 4;
    localparam int unsigned DEFAULT_PAYLOAD_BITS  = 142;
    localparam int unsigned DEFAULT_TAIL_BITS     = 3;
    localparam int unsigned DEFAULT_FLUSH_SYMBOLS = 2;
    localparam int unsigned DEFAULT_GUARD_SYMBOLS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_HEAD,
        ST_PAYLOAD,
        ST_TRAIL,
        ST_FLUSH,
        ST_GUARD
    } seq_state_e;

    function automatic int unsigned max_len(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    localparam int unsigned DEFAULT_MAX_LEN = max_len(DEFAULT_PAYLOAD_BITS, DEFAULT_TAIL_BITS,
                                                      DEFAULT_FLUSH_SYMBOLS, DEFAULT_GUARD_SYMBOLS);
    localparam int unsigned DEFAULT_CNT_W   = $clog2(DEFAULT_MAX_LEN + 1);

    // Successor of each framed state once its symbol budget is spent.
    function automatic seq_state_e next_framed_state(input seq_state_e s);
        seq_state_e n;
        n = ST_IDLE;
        case (s)
            ST_HEAD:    n = ST_PAYLOAD;
            ST_PAYLOAD: n = ST_TRAIL;
            ST_TRAIL:   n = ST_FLUSH;
            ST_FLUSH:   n = ST_GUARD;
            default:    n = ST_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/gmsk_burst_sequencer_if.sv
// Bit-stream handshake between the burst bit source (master) and the sequencer (slave).
interface gmsk_burst_sequencer_if;
    logic bit_data;
    logic bit_valid;
    logic bit_ready;

    modport master (output bit_data, output bit_valid, input bit_ready);
    modport slave  (input bit_data, input bit_valid, output bit_ready);
endinterface

// File: rtl/gmsk_strobe_divider.sv
// Free-running sample strobe divider; strobe on the last count, held high when SAMPLE_DIVIDE is 1.
module gmsk_strobe_divider
    import gmsk_pkg::*;
#(
    parameter int unsigned SAMPLE_DIVIDE = DEFAULT_SAMPLE_DIVIDE
) (
    input  logic clock,
    input  logic reset,
    output logic sample_strobe
);
    localparam int unsigned CNT_W = (SAMPLE_DIVIDE > 1) ? $clog2(SAMPLE_DIVIDE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIVIDE - 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (count_q == LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign sample_strobe = (count_q == LAST);
endmodule

// File: rtl/gmsk_burst_sequencer.sv
// Frames one GSM normal burst (tails, payload, tails, flush, guard) into the GMSK modulator.
// Optional macro GMSK_DIFF_ENCODE_EN differentially encodes every framed symbol.
module gmsk_burst_sequencer
    import gmsk_pkg::*;
#(
    parameter int unsigned SAMPLE_DIVIDE = DEFAULT_SAMPLE_DIVIDE,
    parameter int unsigned PAYLOAD_BITS  = DEFAULT_PAYLOAD_BITS,
    parameter int unsigned TAIL_BITS     = DEFAULT_TAIL_BITS,
    parameter int unsigned FLUSH_SYMBOLS = DEFAULT_FLUSH_SYMBOLS,
    parameter int unsigned GUARD_SYMBOLS = DEFAULT_GUARD_SYMBOLS
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    gmsk_burst_sequencer_if.slave  bits,
    input  logic                   next_symbol_strobe,
    output logic                   sample_strobe,
    output logic                   current_symbol,
    output logic                   tx_enable,
    output logic                   busy,
    output logic                   burst_done,
    output logic                   underrun
);
    localparam int unsigned MAX_LEN = max_len(PAYLOAD_BITS, TAIL_BITS, FLUSH_SYMBOLS, GUARD_SYMBOLS);
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sym_q, sym_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             under_q, under_d;
`ifdef GMSK_DIFF_ENCODE_EN
    logic             prev_q, prev_d;
    logic             enc_sym;
`endif

    logic             boundary_c;
    logic [CNT_W-1:0] len_c;
    logic             last_c;
    logic             bit_ready_c;
    logic             raw_sym;
    logic             load_sym;
    logic             restart_prev;

    gmsk_strobe_divider #(
        .SAMPLE_DIVIDE (SAMPLE_DIVIDE)
    ) u_divider (
        .clock         (clock),
        .reset         (reset),
        .sample_strobe (sample_strobe)
    );

    assign boundary_c = sample_strobe && next_symbol_strobe;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sym_q   <= 1'b0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            under_q <= 1'b0;
`ifdef GMSK_DIFF_ENCODE_EN
            prev_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            under_q <= under_d;
`ifdef GMSK_DIFF_ENCODE_EN
            prev_q  <= prev_d;
`endif
        end
    end

    // Next-state and registered-output values; everything advances only on a symbol boundary
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sym_d        = sym_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        under_d      = under_q;
        raw_sym      = 1'b0;
        load_sym     = 1'b0;
        restart_prev = 1'b0;
`ifdef GMSK_DIFF_ENCODE_EN
        prev_d       = prev_q;
        enc_sym      = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                sym_d = 1'b0;
                if (start) begin
                    state_d = ST_ARMED;
                    busy_d  = 1'b1;
                    under_d = 1'b0;
                end
            end
            ST_ARMED: begin
                if (boundary_c) begin
                    state_d      = ST_HEAD;
                    cnt_d        = '0;
                    tx_d         = 1'b1;
                    load_sym     = 1'b1;
                    restart_prev = 1'b1;
                end
            end
            ST_HEAD, ST_PAYLOAD, ST_TRAIL, ST_FLUSH: begin
                if (boundary_c) begin
                    load_sym = 1'b1;
                    cnt_d    = last_c ? '0 : cnt_q + CNT_W'(1);
                    if (last_c) state_d = next_framed_state(state_q);
                    if (bit_ready_c) begin
                        raw_sym = bits.bit_valid & bits.bit_data;
                        if (!bits.bit_valid) under_d = 1'b1;
                    end
                    // Guard symbols go out raw with the transmitter gated off
                    if (last_c && state_q == ST_FLUSH) begin
                        load_sym = 1'b0;
                        sym_d    = 1'b0;
                        tx_d     = 1'b0;
                    end
                end
            end
            ST_GUARD: begin
                if (boundary_c) begin
                    cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
                    if (last_c) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_sym) begin
`ifdef GMSK_DIFF_ENCODE_EN
            // prev tracks the last encoded symbol and restarts at 1 on every burst
            enc_sym = raw_sym ^ (restart_prev ? 1'b1 : prev_q);
            sym_d   = enc_sym;
            prev_d  = enc_sym;
`else
            sym_d   = raw_sym;
`endif
        end
    end

    // Output decode: per-state symbol budget and the combinational bit_ready
    always_comb begin
        len_c = CNT_W'(1);
        unique case (state_q)
            ST_HEAD, ST_TRAIL: len_c = CNT_W'(TAIL_BITS);
            ST_PAYLOAD:        len_c = CNT_W'(PAYLOAD_BITS);
            ST_FLUSH:          len_c = CNT_W'(FLUSH_SYMBOLS);
            ST_GUARD:          len_c = CNT_W'(GUARD_SYMBOLS);
            default:           len_c = CNT_W'(1);
        endcase
        last_c      = (cnt_q == len_c - CNT_W'(1));
        bit_ready_c = !reset && boundary_c &&
                      ((state_q == ST_HEAD && last_c) || (state_q == ST_PAYLOAD && !last_c));
    end

    assign bits.bit_ready = bit_ready_c;
    assign current_symbol = sym_q;
    assign tx_enable      = tx_q;
    assign busy           = busy_q;
    assign burst_done     = done_q;
    assign underrun       = under_q;
endmodule

// File: tb/tb_gmsk_burst_sequencer.sv
// Directed bench for gmsk_burst_sequencer with a behavioural 31-sample modulator and bit source.
module tb_gmsk_burst_sequencer;
    import gmsk_pkg::*;

    localparam int unsigned PAY      = DEFAULT_PAYLOAD_BITS;
    localparam int unsigned SYM_CLK  = SAMPLES_PER_SYMBOL * DEFAULT_SAMPLE_DIVIDE;  // 124
    localparam int unsigned TX_SYMS  = 3 + PAY + 3 + 2;                               // 150
    localparam int unsigned BURST_SYMS = TX_SYMS + 8;                                 // 158

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic next_symbol_strobe;
    logic sample_strobe;
    logic current_symbol;
    logic tx_enable;
    logic busy;
    logic burst_done;
    logic underrun;

    gmsk_burst_sequencer_if bits();

    gmsk_burst_sequencer dut (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
        .bits               (bits),
        .next_symbol_strobe (next_symbol_strobe),
        .sample_strobe      (sample_strobe),
        .current_symbol     (current_symbol),
        .tx_enable          (tx_enable),
        .busy               (busy),
        .burst_done         (burst_done),
        .underrun           (underrun)
    );

    always #5 clock = ~clock;

    // Modulator model: sample index 0..30 advancing on each sample strobe
    int unsigned sample_idx = 0;
    always @(posedge clock) begin
        if (reset) sample_idx <= 0;
        else if (sample_strobe) sample_idx <= (sample_idx == SAMPLES_PER_SYMBOL - 1) ? 0 : sample_idx + 1;
    end
    assign next_symbol_strobe = (sample_idx == SAMPLES_PER_SYMBOL - 1);
    wire boundary = sample_strobe && next_symbol_strobe;

    // Statistics gathered independently of the checking code
    logic        sym_log[$];
    int unsigned ready_total = 0;
    int unsigned done_total  = 0;
    int unsigned tx_clocks   = 0;
    always @(negedge clock) if (boundary && tx_enable) sym_log.push_back(current_symbol);
    always @(posedge clock) begin
        if (bits.bit_ready) ready_total <= ready_total + 1;
        if (burst_done)     done_total  <= done_total + 1;
        if (tx_enable)      tx_clocks   <= tx_clocks + 1;
    end

    // Bit source driven from a pattern indexed by the ready pulses of the current burst
    int unsigned    ready_base = 0;
    logic [PAY-1:0] pat = '1;
    bit             starve_en = 1'b0;
    int unsigned    pay_idx;
    always_comb begin
        pay_idx        = ready_total - ready_base;
        bits.bit_data  = (pay_idx < PAY) ? pat[pay_idx] : 1'b0;
        bits.bit_valid = !(starve_en && pay_idx >= 10 && pay_idx <= 12);
    end

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic exp_raw(input int i, input logic [PAY-1:0] p, input bit starve);
        int j;
        if (i < 3 || i >= 3 + int'(PAY)) return 1'b0;
        j = i - 3;
        if (starve && j >= 10 && j <= 12) return 1'b0;
        return p[j];
    endfunction

    task automatic run_burst(input bit coincident, input bit busy_start, input bit starve);
        int unsigned log_base, ready_b, done_b, tx_b, nb, n;
        time t0, t1;
        logic e;
`ifdef GMSK_DIFF_ENCODE_EN
        logic prev;
`endif
        @(posedge clock); #1;
        starve_en  = starve;
        ready_base = ready_total;
        ready_b    = ready_total;
        log_base   = sym_log.size();
        done_b     = done_total;
        tx_b       = tx_clocks;
        if (coincident) begin
            n = 0;
            while (!boundary && n < 2 * SYM_CLK) begin @(negedge clock); n++; end
            check_eq("boundary_seen", 32'(n < 2 * SYM_CLK), 1);
            repeat (SYM_CLK) @(posedge clock);
            #1 start = 1'b1;
            @(negedge clock);
            check_eq("start_on_boundary", 32'(boundary), 1);
        end else begin
            start = 1'b1;
        end
        @(posedge clock); #1 start = 1'b0;
        check_eq("busy_on_accept", 32'(busy), 1);
        check_eq("underrun_cleared", 32'(underrun), 0);

        // ARMED always waits for one full boundary before HEAD
        nb = 0; n = 0;
        while (!tx_enable && n < 3 * SYM_CLK) begin
            @(negedge clock);
            if (boundary && !tx_enable) nb++;
            n++;
        end
        check_eq("arm_wait_boundaries", nb, 1);
        t0 = $time;

        n = 0;
        while (!burst_done && n < 25000) begin
            @(negedge clock);
            n++;
            start = (busy_start && n == 3000);
        end
        start = 1'b0;
        check_eq("done_seen", 32'(burst_done), 1);
        t1 = $time;
        check_eq("head_to_done_clocks", 32'((t1 - t0) / 10), BURST_SYMS * SYM_CLK);

        @(posedge clock); #1;
        check_eq("done_one_cycle", 32'(burst_done), 0);
        check_eq("busy_after_done", 32'(busy), 0);
        check_eq("tx_after_done", 32'(tx_enable), 0);
        check_eq("ready_pulses", ready_total - ready_b, PAY);
        check_eq("done_pulses", done_total - done_b, 1);
        check_eq("tx_clocks", tx_clocks - tx_b, TX_SYMS * SYM_CLK);
        check_eq("tx_symbols", 32'(sym_log.size()) - log_base, TX_SYMS);
        check_eq("underrun_end", 32'(underrun), 32'(starve));

`ifdef GMSK_DIFF_ENCODE_EN
        prev = 1'b1;
`endif
        for (int i = 0; i < int'(TX_SYMS); i++) begin
            e = exp_raw(i, pat, starve);
`ifdef GMSK_DIFF_ENCODE_EN
            e    = e ^ prev;
            prev = e;
`endif
            if (log_base + i < sym_log.size())
                check_eq($sformatf("sym%0d", i), 32'(sym_log[log_base + i]), 32'(e));
        end

        if (busy_start) begin
            repeat (2 * SYM_CLK) @(posedge clock);
            #1 check_eq("busy_start_ignored", 32'(busy), 0);
        end
    endtask

    task automatic reset_mid_burst();
        int unsigned ready_b, done_b, n;
        @(posedge clock); #1;
        starve_en  = 1'b0;
        ready_base = ready_total;
        ready_b    = ready_total;
        start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        n = 0;
        while (ready_total - ready_b < 50 && n < 10000) begin @(posedge clock); #1; n++; end
        check_eq("reached_payload50", ready_total - ready_b, 50);
        check_eq("payload_symbol_high", 32'(current_symbol), 1);
        done_b = done_total;
        reset = 1'b1;
        @(posedge clock); #1;
        check_eq("reset_outputs",
                 32'({tx_enable, busy, bits.bit_ready, burst_done, current_symbol, underrun, sample_strobe}), 0);
        reset = 1'b0;
        repeat (2 * SYM_CLK) @(posedge clock);
        #1;
        check_eq("no_done_after_reset", done_total - done_b, 0);
        check_eq("idle_after_reset", 32'({busy, tx_enable}), 0);
    endtask

    initial begin
        logic [7:0] strobes;
        time t_rel, t_b0, t_b1;
        int unsigned n;

        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_tx_enable", 32'(tx_enable), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_burst_done", 32'(burst_done), 0);
        check_eq("rst_underrun", 32'(underrun), 0);
        check_eq("rst_current_symbol", 32'(current_symbol), 0);
        check_eq("rst_bit_ready", 32'(bits.bit_ready), 0);
        check_eq("rst_sample_strobe", 32'(sample_strobe), 0);

        // Divider phase: strobe on every 4th clock, the first on clock 4
        @(negedge clock);
        reset = 1'b0;
        t_rel = $time;
        strobes[0] = sample_strobe;
        for (int i = 1; i < 8; i++) begin
            @(negedge clock);
            strobes[i] = sample_strobe;
        end
        check_eq("strobe_pattern", 32'(strobes), 32'h88);

        n = 0;
        while (!boundary && n < 400) begin @(negedge clock); n++; end
        t_b0 = $time;
        check_eq("first_boundary_clock", 32'((t_b0 - t_rel) / 10), SYM_CLK - 1);
        @(negedge clock);
        n = 0;
        while (!boundary && n < 400) begin @(negedge clock); n++; end
        t_b1 = $time;
        check_eq("boundary_period", 32'((t_b1 - t_b0) / 10), SYM_CLK);

        // Nominal all-ones burst with a start coincident with B and a start while busy
        pat = '1;
        run_burst(1'b1, 1'b1, 1'b0);

        reset_mid_burst();

        // Post-reset burst: payload 1,0,1,1,1... with symbols 10-12 starved
        pat    = '1;
        pat[1] = 1'b0;
        run_burst(1'b0, 1'b0, 1'b1);

        repeat (3 * SYM_CLK) @(posedge clock);
        #1 check_eq("underrun_sticky", 32'(underrun), 1);
        start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        check_eq("underrun_clear_on_start", 32'(underrun), 0);
        check_eq("busy_on_restart", 32'(busy), 1);
        reset = 1'b1;
        repeat (2) @(posedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
